pa_tcipif_arb: RTL
==================

# pa_tcipif_arb

Two-requester arbiter and sequencer for the shared TCIP slave bus. It sits between the BMU instruction-bus and data-bus ports and the CLINT, CLIC and sysmap register slaves. It grants one bus at a time using round-robin, decodes the TCIP offset, and drives a single-cycle select to exactly one slave. It then holds the transaction until the slave completes or a timeout expires, and returns data or an access error to the granted requester.

## Interface
Parameters:
- TIMEOUT, 255 — cycles allowed from slave select to slave cmplt before an error response; range 1..255.

Ports (clock and reset first):
- forever_cpuclk  in  1  — clock.
- cpurst_b  in  1  — reset; asynchronous, active-low.
- pad_cpu_tcip_base  in  32  — TCIP region base; only bits [31:16] are compared.
- bmu_tcipif_{ibus,dbus}_req  in  1  — request, held until grnt.
- bmu_tcipif_{ibus,dbus}_addr  in  32  — byte address.
- bmu_tcipif_{ibus,dbus}_wdata  in  32  — write data.
- bmu_tcipif_{ibus,dbus}_write  in  1  — 1 = write.
- bmu_tcipif_{ibus,dbus}_size  in  2  — 0 = byte, 1 = half, 2 = word.
- bmu_tcipif_{ibus,dbus}_acc_deny  in  1  — PMP/privilege deny.
- tcipif_bmu_{ibus,dbus}_grnt  out  1  — request accepted (combinational).
- tcipif_bmu_{ibus,dbus}_trans_cmplt  out  1  — one-cycle completion pulse.
- tcipif_bmu_{ibus,dbus}_data  out  32  — read data, valid only with trans_cmplt, otherwise 0.
- tcipif_bmu_{ibus,dbus}_acc_err  out  1  — error, valid only with trans_cmplt.
- tcipif_clint_sel, tcipif_clic_sel, tcipif_sysmap_sel  out  1  — one-cycle slave select.
- tcipif_xx_addr  out  16  — registered offset.
- tcipif_xx_wdata  out  32  — registered write data.
- tcipif_xx_write  out  1  — registered write flag.
- tcipif_clic_size  out  2  — registered size.
- {clint,clic,sysmap}_tcipif_cmplt  in  1  — slave done.
- {clint,clic,sysmap}_tcipif_rdata  in  32  — slave read data.

## Operation
- States: IDLE, ACCESS, WAIT, RESP, ERR.
- Arbitration (IDLE only):
  - Winner = requesting bus with priority; if only one bus requests, it wins.
  - grnt is asserted combinationally to the winner in IDLE.
  - The priority pointer flips to the loser on every grant. Reset priority = dbus.
- On grant, register the following: owner, addr[15:0], wdata, write, size, and the decoded target.
- Decode:
  - Hit = addr[31:16] == base[31:16].
  - offset[15:14] = 00 → CLINT; 01 → CLIC; 1x → sysmap.
- Error classes. Any of these sends the FSM IDLE → ERR, and no select is issued:
  - acc_deny = 1.
  - miss (no hit).
  - CLINT target with size ≠ 2.
  - sysmap target with size ≠ 2.
  - addr not aligned to size.
- IDLE → ACCESS for valid requests. In ACCESS, exactly one sel is high for one cycle.
- ACCESS/WAIT:
  - The target's cmplt → RESP, and the target's rdata is captured.
  - A cmplt from a non-target slave is ignored.
- Timeout counter (8 bits):
  - Cleared on entry to ACCESS; increments each cycle without cmplt.
  - Reaching TIMEOUT → ERR.
  - A late cmplt that arrives in IDLE is ignored.
- RESP: owner trans_cmplt = 1, data = captured rdata (0 for writes), acc_err = 0. Next state is IDLE.
- ERR: owner trans_cmplt = 1, acc_err = 1, data = 0. Next state is IDLE.
- No grant is issued in ACCESS, WAIT, RESP or ERR. A request arriving in those states waits.
- Reset (asynchronous, any state):
  - State = IDLE, priority = dbus, counter = 0, all registers = 0.
  - All outputs = 0, except grnt, which follows the IDLE combinational logic.
  - An in-flight transaction is abandoned with no completion.

## Timing
- Successful access:
  - Cycle 0: grant.
  - Cycle 1: sel.
  - Cycle k ≥ 1: slave cmplt, in the same cycle as sel or later.
  - Cycle k+1: trans_cmplt.
  - Minimum grant-to-cmplt latency is 2 cycles.
- Error access: grant at cycle 0, trans_cmplt + acc_err at cycle 1.
- Timeout: sel at cycle 1, acc_err at cycle 1 + TIMEOUT + 1.
- Back-to-back: the next grant occurs no earlier than the cycle after trans_cmplt, so the minimum period is 3 cycles per transaction.
- Slave address, wdata, write and size outputs are stable from the ACCESS cycle until the next grant.

## Test plan
- Base = 0xE0000000. dbus word read of 0xE0000004; CLINT cmplt in the same cycle as sel with rdata = 0x12345678. Required: clint_sel pulses at cycle 1, xx_addr = 0x0004, dbus trans_cmplt at cycle 2 with data = 0x12345678 and acc_err = 0.
- ibus and dbus request together, repeatedly. Required: grants alternate dbus, ibus, dbus; each owner sees only its own trans_cmplt.
- dbus byte write to 0xE0004001 (CLIC), wdata = 0xA5. Required: clic_sel pulses, clic_size = 0, xx_write = 1, xx_addr = 0x4001. CLIC cmplt 5 cycles later → trans_cmplt with acc_err = 0.
- Error cases, each expected to give acc_err at cycle 1 with no sel issued:
  - dbus to 0xD0000000 (miss).
  - dbus with acc_deny = 1.
  - half-word access to CLINT.
- TIMEOUT = 4, sysmap never completes. Required: acc_err at cycle 6. A sysmap cmplt at cycle 8 is ignored, and the next request is served normally.
- cpurst_b asserted while in WAIT. Required: all outputs go to 0 immediately and no trans_cmplt is issued. After release, the first request is granted to dbus.

Source files
------------

// File: rtl/pa_tcipif_arb_if.sv
// Bus bundle between the BMU ibus/dbus requesters, the TCIP arbiter and the
// CLINT/CLIC/sysmap register slaves. The slave modport is the arbiter's view.
interface pa_tcipif_arb_if;
  logic        bmu_tcipif_ibus_req;
  logic [31:0] bmu_tcipif_ibus_addr;
  logic [31:0] bmu_tcipif_ibus_wdata;
  logic        bmu_tcipif_ibus_write;
  logic [1:0]  bmu_tcipif_ibus_size;
  logic        bmu_tcipif_ibus_acc_deny;
  logic        bmu_tcipif_dbus_req;
  logic [31:0] bmu_tcipif_dbus_addr;
  logic [31:0] bmu_tcipif_dbus_wdata;
  logic        bmu_tcipif_dbus_write;
  logic [1:0]  bmu_tcipif_dbus_size;
  logic        bmu_tcipif_dbus_acc_deny;
  logic        tcipif_bmu_ibus_grnt;
  logic        tcipif_bmu_ibus_trans_cmplt;
  logic [31:0] tcipif_bmu_ibus_data;
  logic        tcipif_bmu_ibus_acc_err;
  logic        tcipif_bmu_dbus_grnt;
  logic        tcipif_bmu_dbus_trans_cmplt;
  logic [31:0] tcipif_bmu_dbus_data;
  logic        tcipif_bmu_dbus_acc_err;
  logic        tcipif_clint_sel;
  logic        tcipif_clic_sel;
  logic        tcipif_sysmap_sel;
  logic [15:0] tcipif_xx_addr;
  logic [31:0] tcipif_xx_wdata;
  logic        tcipif_xx_write;
  logic [1:0]  tcipif_clic_size;
  logic        clint_tcipif_cmplt;
  logic [31:0] clint_tcipif_rdata;
  logic        clic_tcipif_cmplt;
  logic [31:0] clic_tcipif_rdata;
  logic        sysmap_tcipif_cmplt;
  logic [31:0] sysmap_tcipif_rdata;

  modport slave (
    input  bmu_tcipif_ibus_req, bmu_tcipif_ibus_addr, bmu_tcipif_ibus_wdata,
           bmu_tcipif_ibus_write, bmu_tcipif_ibus_size, bmu_tcipif_ibus_acc_deny,
           bmu_tcipif_dbus_req, bmu_tcipif_dbus_addr, bmu_tcipif_dbus_wdata,
           bmu_tcipif_dbus_write, bmu_tcipif_dbus_size, bmu_tcipif_dbus_acc_deny,
           clint_tcipif_cmplt, clint_tcipif_rdata, clic_tcipif_cmplt,
           clic_tcipif_rdata, sysmap_tcipif_cmplt, sysmap_tcipif_rdata,
    output tcipif_bmu_ibus_grnt, tcipif_bmu_ibus_trans_cmplt, tcipif_bmu_ibus_data,
           tcipif_bmu_ibus_acc_err, tcipif_bmu_dbus_grnt, tcipif_bmu_dbus_trans_cmplt,
           tcipif_bmu_dbus_data, tcipif_bmu_dbus_acc_err, tcipif_clint_sel,
           tcipif_clic_sel, tcipif_sysmap_sel, tcipif_xx_addr, tcipif_xx_wdata,
           tcipif_xx_write, tcipif_clic_size
  );

  modport master (
    output bmu_tcipif_ibus_req, bmu_tcipif_ibus_addr, bmu_tcipif_ibus_wdata,
           bmu_tcipif_ibus_write, bmu_tcipif_ibus_size, bmu_tcipif_ibus_acc_deny,
           bmu_tcipif_dbus_req, bmu_tcipif_dbus_addr, bmu_tcipif_dbus_wdata,
           bmu_tcipif_dbus_write, bmu_tcipif_dbus_size, bmu_tcipif_dbus_acc_deny,
           clint_tcipif_cmplt, clint_tcipif_rdata, clic_tcipif_cmplt,
           clic_tcipif_rdata, sysmap_tcipif_cmplt, sysmap_tcipif_rdata,
    input  tcipif_bmu_ibus_grnt, tcipif_bmu_ibus_trans_cmplt, tcipif_bmu_ibus_data,
           tcipif_bmu_ibus_acc_err, tcipif_bmu_dbus_grnt, tcipif_bmu_dbus_trans_cmplt,
           tcipif_bmu_dbus_data, tcipif_bmu_dbus_acc_err, tcipif_clint_sel,
           tcipif_clic_sel, tcipif_sysmap_sel, tcipif_xx_addr, tcipif_xx_wdata,
           tcipif_xx_write, tcipif_clic_size
  );
endinterface

// File: rtl/pa_tcipif_arb.sv
// Round-robin ibus/dbus arbiter and sequencer for the TCIP register slaves
// (CLINT, CLIC, sysmap) with decode, access checks and completion timeout.
module pa_tcipif_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic           forever_cpuclk,
  input  logic           cpurst_b,
  input  logic [31:0]    pad_cpu_tcip_base,
  pa_tcipif_arb_if.slave bus
);
  // state  | meaning
  // IDLE   | arbitrate, grant winner, decode and check the request
  // ACCESS | one-cycle select to the decoded slave
  // WAIT   | wait for target cmplt or timeout
  // RESP   | completion pulse with captured read data to owner
  // ERR    | completion pulse with acc_err to owner
  typedef enum logic [2:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP, ST_ERR} state_e;
  typedef enum logic [1:0] {TGT_CLINT, TGT_CLIC, TGT_SYSMAP} tgt_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        prio_dbus_q, prio_dbus_d;
  logic        owner_dbus_q, owner_dbus_d;
  tgt_e        tgt_q, tgt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        clint_sel_q, clint_sel_d;
  logic        clic_sel_q, clic_sel_d;
  logic        sysmap_sel_q, sysmap_sel_d;
  logic        ibus_cmplt_q, ibus_cmplt_d;
  logic        dbus_cmplt_q, dbus_cmplt_d;
  logic        ibus_err_q, ibus_err_d;
  logic        dbus_err_q, dbus_err_d;
  logic [31:0] ibus_data_q, ibus_data_d;
  logic [31:0] dbus_data_q, dbus_data_d;

  logic        ibus_win, dbus_win, grant_any;
  logic [31:0] req_addr, req_wdata;
  logic        req_write, req_deny, req_misalign, req_bad;
  logic [1:0]  req_size;
  tgt_e        req_tgt;
  logic        tgt_cmplt;
  logic [31:0] tgt_rdata, resp_data;
  logic        base_unused;

  assign base_unused = ^pad_cpu_tcip_base[15:0];

  // Priority pointer names the bus that wins a tie.
  assign ibus_win  = (state_q == ST_IDLE) && bus.bmu_tcipif_ibus_req &&
                     (!prio_dbus_q || !bus.bmu_tcipif_dbus_req);
  assign dbus_win  = (state_q == ST_IDLE) && bus.bmu_tcipif_dbus_req &&
                     (prio_dbus_q || !bus.bmu_tcipif_ibus_req);
  assign grant_any = ibus_win | dbus_win;

  assign req_addr  = dbus_win ? bus.bmu_tcipif_dbus_addr     : bus.bmu_tcipif_ibus_addr;
  assign req_wdata = dbus_win ? bus.bmu_tcipif_dbus_wdata    : bus.bmu_tcipif_ibus_wdata;
  assign req_write = dbus_win ? bus.bmu_tcipif_dbus_write    : bus.bmu_tcipif_ibus_write;
  assign req_size  = dbus_win ? bus.bmu_tcipif_dbus_size     : bus.bmu_tcipif_ibus_size;
  assign req_deny  = dbus_win ? bus.bmu_tcipif_dbus_acc_deny : bus.bmu_tcipif_ibus_acc_deny;

  always_comb begin
    req_tgt = TGT_CLINT;
    if (req_addr[15])      req_tgt = TGT_SYSMAP;
    else if (req_addr[14]) req_tgt = TGT_CLIC;
    req_misalign = 1'b1;
    case (req_size)
      2'd0:    req_misalign = 1'b0;
      2'd1:    req_misalign = req_addr[0];
      2'd2:    req_misalign = |req_addr[1:0];
      default: req_misalign = 1'b1;
    endcase
    // Only the CLIC accepts sub-word accesses.
    req_bad = req_deny || (req_addr[31:16] != pad_cpu_tcip_base[31:16]) ||
              req_misalign || ((req_tgt != TGT_CLIC) && (req_size != 2'd2));
  end

  always_comb begin
    tgt_cmplt = 1'b0;
    tgt_rdata = '0;
    case (tgt_q)
      TGT_CLINT:  begin tgt_cmplt = bus.clint_tcipif_cmplt;  tgt_rdata = bus.clint_tcipif_rdata;  end
      TGT_CLIC:   begin tgt_cmplt = bus.clic_tcipif_cmplt;   tgt_rdata = bus.clic_tcipif_rdata;   end
      TGT_SYSMAP: begin tgt_cmplt = bus.sysmap_tcipif_cmplt; tgt_rdata = bus.sysmap_tcipif_rdata; end
      default:    begin tgt_cmplt = 1'b0;                    tgt_rdata = '0;                      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    prio_dbus_d  = prio_dbus_q;
    owner_dbus_d = owner_dbus_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    size_d       = size_q;
    clint_sel_d  = 1'b0;
    clic_sel_d   = 1'b0;
    sysmap_sel_d = 1'b0;
    ibus_cmplt_d = 1'b0;
    dbus_cmplt_d = 1'b0;
    ibus_err_d   = 1'b0;
    dbus_err_d   = 1'b0;
    ibus_data_d  = '0;
    dbus_data_d  = '0;
    resp_data    = write_q ? '0 : tgt_rdata;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          prio_dbus_d  = ibus_win;
          owner_dbus_d = dbus_win;
          addr_d       = req_addr[15:0];
          wdata_d      = req_wdata;
          write_d      = req_write;
          size_d       = req_size;
          tgt_d        = req_tgt;
          cnt_d        = '0;
          if (req_bad) begin
            state_d      = ST_ERR;
            ibus_cmplt_d = ibus_win;
            dbus_cmplt_d = dbus_win;
            ibus_err_d   = ibus_win;
            dbus_err_d   = dbus_win;
          end else begin
            state_d      = ST_ACCESS;
            clint_sel_d  = (req_tgt == TGT_CLINT);
            clic_sel_d   = (req_tgt == TGT_CLIC);
            sysmap_sel_d = (req_tgt == TGT_SYSMAP);
          end
        end
      end
      ST_ACCESS, ST_WAIT: begin
        // A completion landing on the last allowed cycle still wins over timeout.
        if (tgt_cmplt) begin
          state_d      = ST_RESP;
          ibus_cmplt_d = !owner_dbus_q;
          dbus_cmplt_d = owner_dbus_q;
          ibus_data_d  = owner_dbus_q ? '0 : resp_data;
          dbus_data_d  = owner_dbus_q ? resp_data : '0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d      = ST_ERR;
          ibus_cmplt_d = !owner_dbus_q;
          dbus_cmplt_d = owner_dbus_q;
          ibus_err_d   = !owner_dbus_q;
          dbus_err_d   = owner_dbus_q;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q      <= ST_IDLE;
      prio_dbus_q  <= 1'b1;
      owner_dbus_q <= 1'b0;
      tgt_q        <= TGT_CLINT;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      clint_sel_q  <= 1'b0;
      clic_sel_q   <= 1'b0;
      sysmap_sel_q <= 1'b0;
      ibus_cmplt_q <= 1'b0;
      dbus_cmplt_q <= 1'b0;
      ibus_err_q   <= 1'b0;
      dbus_err_q   <= 1'b0;
      ibus_data_q  <= '0;
      dbus_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      prio_dbus_q  <= prio_dbus_d;
      owner_dbus_q <= owner_dbus_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      size_q       <= size_d;
      clint_sel_q  <= clint_sel_d;
      clic_sel_q   <= clic_sel_d;
      sysmap_sel_q <= sysmap_sel_d;
      ibus_cmplt_q <= ibus_cmplt_d;
      dbus_cmplt_q <= dbus_cmplt_d;
      ibus_err_q   <= ibus_err_d;
      dbus_err_q   <= dbus_err_d;
      ibus_data_q  <= ibus_data_d;
      dbus_data_q  <= dbus_data_d;
    end
  end

  assign bus.tcipif_bmu_ibus_grnt        = ibus_win;
  assign bus.tcipif_bmu_dbus_grnt        = dbus_win;
  assign bus.tcipif_bmu_ibus_trans_cmplt = ibus_cmplt_q;
  assign bus.tcipif_bmu_dbus_trans_cmplt = dbus_cmplt_q;
  assign bus.tcipif_bmu_ibus_acc_err     = ibus_err_q;
  assign bus.tcipif_bmu_dbus_acc_err     = dbus_err_q;
  assign bus.tcipif_bmu_ibus_data        = ibus_data_q;
  assign bus.tcipif_bmu_dbus_data        = dbus_data_q;
  assign bus.tcipif_clint_sel            = clint_sel_q;
  assign bus.tcipif_clic_sel             = clic_sel_q;
  assign bus.tcipif_sysmap_sel           = sysmap_sel_q;
  assign bus.tcipif_xx_addr              = addr_q;
  assign bus.tcipif_xx_wdata             = wdata_q;
  assign bus.tcipif_xx_write             = write_q;
  assign bus.tcipif_clic_size            = size_q;
endmodule
